// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch port and the data port.
// Define ARB_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_owner_d;
  logic       r_owner_we;
  logic       r_kill;

  logic w_retire;
  logic w_slot;
  logic w_issue;
  logic w_pick_d;

  assign w_retire = (r_state == BUSY) && (r_cnt == 4'd0);
  // Reset also closes the slot so no grant leaks out while reset is held.
  assign w_slot   = !reset && ((r_state == IDLE) || w_retire);
  assign w_issue  = w_slot && (if_req || d_req);

`ifdef ARB_RR_EN
  logic r_last_d;

  assign w_pick_d = d_req && (!if_req || !r_last_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_last_d <= 1'b0;
    else if (w_issue) r_last_d <= w_pick_d;
  end
`else
  assign w_pick_d = d_req;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;

    if (w_issue) begin
      if_gnt      = !w_pick_d;
      d_gnt       = w_pick_d;
      mem_en      = 1'b1;
      mem_we      = w_pick_d && d_we;
      mem_addr    = w_pick_d ? d_addr : if_addr;
      mem_wdata   = w_pick_d ? d_wdata : '0;
      w_state_nxt = BUSY;
      w_cnt_nxt   = CNT_INIT;
    end else if (w_retire) begin
      w_state_nxt = IDLE;
    end else if (r_state == BUSY) begin
      w_cnt_nxt   = r_cnt - 4'd1;
    end
  end

  // A flush arriving on the retire cycle itself also suppresses the stale word.
  assign if_rvalid = w_retire && !r_owner_d && !r_kill && !if_flush;
  assign d_rvalid  = w_retire && r_owner_d;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !r_owner_we) ? mem_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_d  <= 1'b0;
      r_owner_we <= 1'b0;
      r_kill     <= 1'b0;
    end else if (w_issue) begin
      r_owner_d  <= w_pick_d;
      r_owner_we <= w_pick_d && d_we;
      r_kill     <= !w_pick_d && if_flush;
    end else if (w_retire) begin
      r_kill     <= 1'b0;
    end else if ((r_state == BUSY) && !r_owner_d && if_flush) begin
      r_kill     <= 1'b1;
    end
  end

endmodule
